// File: rtl/sakebi_eth_fcs_rx.sv
// Ethernet receive framer: strips preamble/SFD/FCS, checks CRC-32 and forwards the MAC frame
// with a bad-frame flag on the last beat.
module sakebi_eth_fcs_rx #(
   parameter int unsigned MIN_FRAME = 64,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             i_axis_ACLK,
   input  logic             i_axis_ARESETn,
   input  logic             i_s_axis_TVALID,
   output logic             o_s_axis_TREADY,
   input  logic [7:0]       i_s_axis_TDATA,
   input  logic             i_s_axis_TLAST,
   output logic             o_m_axis_TVALID,
   input  logic             i_m_axis_TREADY,
   output logic [7:0]       o_m_axis_TDATA,
   output logic             o_m_axis_TLAST,
   output logic             o_m_axis_TUSER,
   output logic [CNT_W-1:0] o_good_cnt,
   output logic [CNT_W-1:0] o_err_cnt
);

   typedef enum logic [1:0] {StHunt, StData, StDrop} state_e;

   localparam logic [31:0] CrcResidue = 32'hDEBB20E3;
   localparam logic [10:0] LenMax     = 11'd2047;

   state_e           state_q, state_d;
   logic             seen55_q, seen55_d;
   logic [31:0]      crc_q, crc_d, crc_next;
   logic [10:0]      len_q, len_d, len_inc;
   logic [31:0]      dly_q, dly_d;
   logic [2:0]       dly_cnt_q, dly_cnt_d;
   logic             m_valid_q, m_valid_d;
   logic [7:0]       m_data_q, m_data_d;
   logic             m_last_q, m_last_d;
   logic             m_user_q, m_user_d;
   logic [CNT_W-1:0] good_q, good_d, err_q, err_d;
   logic             accept, good_inc, err_inc, frame_bad;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      end
      return r;
   endfunction

   always_comb begin
      state_d   = state_q;
      seen55_d  = seen55_q;
      crc_d     = crc_q;
      len_d     = len_q;
      dly_d     = dly_q;
      dly_cnt_d = dly_cnt_q;
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      m_last_d  = m_last_q;
      m_user_d  = m_user_q;
      good_inc  = 1'b0;
      err_inc   = 1'b0;

      o_s_axis_TREADY = (state_q == StData) ? (!m_valid_q || i_m_axis_TREADY) : 1'b1;
      accept    = i_s_axis_TVALID && o_s_axis_TREADY;
      crc_next  = crc_byte(crc_q, i_s_axis_TDATA);
      len_inc   = (len_q == LenMax) ? len_q : len_q + 11'd1;
      frame_bad = (crc_next != CrcResidue) || (32'(len_inc) < MIN_FRAME);

      if (m_valid_q && i_m_axis_TREADY) begin
         m_valid_d = 1'b0;
      end

      unique case (state_q)
         StHunt: begin
            if (accept) begin
               if (i_s_axis_TLAST) begin
                  seen55_d = 1'b0;
                  err_inc  = 1'b1;
               end else if (i_s_axis_TDATA == 8'h55) begin
                  seen55_d = 1'b1;
               end else if (i_s_axis_TDATA == 8'hD5 && seen55_q) begin
                  state_d   = StData;
                  seen55_d  = 1'b0;
                  crc_d     = 32'hFFFFFFFF;
                  len_d     = 11'd0;
                  dly_cnt_d = 3'd0;
                  dly_d     = 32'h0;
               end else begin
                  state_d  = StDrop;
                  seen55_d = 1'b0;
               end
            end
         end
         StDrop: begin
            if (accept && i_s_axis_TLAST) begin
               state_d = StHunt;
               err_inc = 1'b1;
            end
         end
         StData: begin
            if (accept) begin
               crc_d     = crc_next;
               len_d     = len_inc;
               dly_d     = {dly_q[23:0], i_s_axis_TDATA};
               dly_cnt_d = (dly_cnt_q == 3'd4) ? 3'd4 : dly_cnt_q + 3'd1;
               // A full delay line means len >= 5 with this byte, so the oldest byte is MAC data.
               if (dly_cnt_q == 3'd4) begin
                  m_valid_d = 1'b1;
                  m_data_d  = dly_q[31:24];
                  m_last_d  = i_s_axis_TLAST;
                  m_user_d  = i_s_axis_TLAST && frame_bad;
               end
               if (i_s_axis_TLAST) begin
                  state_d  = StHunt;
                  seen55_d = 1'b0;
                  if (dly_cnt_q == 3'd4 && !frame_bad) begin
                     good_inc = 1'b1;
                  end else begin
                     err_inc = 1'b1;
                  end
               end
            end
         end
         default: state_d = StHunt;
      endcase

      good_d = (good_inc && good_q != '1) ? good_q + 1'b1 : good_q;
      err_d  = (err_inc && err_q != '1) ? err_q + 1'b1 : err_q;
   end

   always_ff @(posedge i_axis_ACLK or negedge i_axis_ARESETn) begin
      if (!i_axis_ARESETn) begin
         state_q   <= StHunt;
         seen55_q  <= 1'b0;
         crc_q     <= 32'hFFFFFFFF;
         len_q     <= 11'd0;
         dly_q     <= 32'h0;
         dly_cnt_q <= 3'd0;
         m_valid_q <= 1'b0;
         m_data_q  <= 8'h0;
         m_last_q  <= 1'b0;
         m_user_q  <= 1'b0;
         good_q    <= '0;
         err_q     <= '0;
      end else begin
         state_q   <= state_d;
         seen55_q  <= seen55_d;
         crc_q     <= crc_d;
         len_q     <= len_d;
         dly_q     <= dly_d;
         dly_cnt_q <= dly_cnt_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         m_last_q  <= m_last_d;
         m_user_q  <= m_user_d;
         good_q    <= good_d;
         err_q     <= err_d;
      end
   end

   assign o_m_axis_TVALID = m_valid_q;
   assign o_m_axis_TDATA  = m_data_q;
   assign o_m_axis_TLAST  = m_last_q;
   assign o_m_axis_TUSER  = m_user_q;
   assign o_good_cnt      = good_q;
   assign o_err_cnt       = err_q;

endmodule

// File: tb/tb_sakebi_eth_fcs_rx.sv
// Directed bench for sakebi_eth_fcs_rx: expected beats are queued when a frame is built and
// checked as the DUT hands them off.
module tb_sakebi_eth_fcs_rx;

   localparam int unsigned MinFrame = 64;
   localparam int unsigned CntW     = 16;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            s_valid = 1'b0;
   logic            s_ready;
   logic [7:0]      s_data = 8'h0;
   logic            s_last = 1'b0;
   logic            m_valid;
   logic            m_ready = 1'b1;
   logic [7:0]      m_data;
   logic            m_last;
   logic            m_user;
   logic [CntW-1:0] good_cnt;
   logic [CntW-1:0] err_cnt;

   sakebi_eth_fcs_rx #(
      .MIN_FRAME(MinFrame),
      .CNT_W    (CntW)
   ) dut (
      .i_axis_ACLK    (clk),
      .i_axis_ARESETn (rst_n),
      .i_s_axis_TVALID(s_valid),
      .o_s_axis_TREADY(s_ready),
      .i_s_axis_TDATA (s_data),
      .i_s_axis_TLAST (s_last),
      .o_m_axis_TVALID(m_valid),
      .i_m_axis_TREADY(m_ready),
      .o_m_axis_TDATA (m_data),
      .o_m_axis_TLAST (m_last),
      .o_m_axis_TUSER (m_user),
      .o_good_cnt     (good_cnt),
      .o_err_cnt      (err_cnt)
   );

   always #5 clk = ~clk;

   int         n_tests = 0;
   int         n_fail = 0;
   int         exp_good = 0;
   int         exp_err = 0;
   logic [9:0] exp_q[$];
   bit         mon_en = 1'b1;
   bit         toggle_en = 1'b0;
   bit         in_data = 1'b0;
   bit         hold = 1'b0;
   logic [9:0] held;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_tests++;
      assert (obs === want) else begin
         n_fail++;
         $error("FAIL %s: got %0h, expected %0h", tag, obs, want);
      end
   endtask

   // Output monitor: pops the scoreboard on each handshake, checks stability under stall.
   always @(negedge clk) begin
      if (!rst_n || !mon_en) begin
         hold = 1'b0;
      end else begin
         if (hold) check("stall_stable", {21'h0, m_valid, m_data, m_last, m_user},
                         {21'h0, 1'b1, held});
         if (m_valid && m_ready) begin
            hold = 1'b0;
            if (exp_q.size() == 0) begin
               check("unexpected_beat", {22'h0, m_data, m_last, m_user}, 32'hFFFFFFFF);
            end else begin
               logic [9:0] e;
               e = exp_q.pop_front();
               check("beat_data", {24'h0, m_data}, {24'h0, e[9:2]});
               check("beat_last", {31'h0, m_last}, {31'h0, e[1]});
               check("beat_user", {31'h0, m_user}, {31'h0, e[0]});
            end
         end else if (m_valid) begin
            hold = 1'b1;
            held = {m_data, m_last, m_user};
         end else begin
            hold = 1'b0;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (toggle_en) m_ready = ~m_ready;
      end
   end

   task automatic send_byte(input logic [7:0] d, input bit last);
      int t;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      t = 0;
      forever begin
         @(negedge clk);
         if (in_data) check("s_ready", {31'h0, s_ready}, {31'h0, !m_valid || m_ready});
         if (s_ready) break;
         t++;
         if (t > 1000) begin
            $display("FAIL send_timeout: s_ready stuck at 0, expected 1");
            $fatal(1, "timeout");
         end
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   function automatic logic [31:0] crc_ref(input logic [7:0] b[$]);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (b[i]) begin
         c ^= {24'h0, b[i]};
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return ~c;
   endfunction

   task automatic run_frame(input int n, input bit corrupt);
      logic [7:0]  p[$];
      logic [31:0] fcs;
      bit          bad;
      for (int i = 0; i < n; i++) p.push_back(8'(i));
      fcs = crc_ref(p);
      if (corrupt) p[16] = p[16] ^ 8'h01;
      bad = corrupt || (n + 4 < MinFrame);
      for (int i = 0; i < n; i++) exp_q.push_back({p[i], (i == n - 1), bad && (i == n - 1)});
      if (bad) exp_err++;
      else exp_good++;
      for (int i = 0; i < 7; i++) send_byte(8'h55, 1'b0);
      send_byte(8'hD5, 1'b0);
      in_data = 1'b1;
      foreach (p[i]) send_byte(p[i], 1'b0);
      for (int i = 0; i < 4; i++) send_byte(fcs[8*i +: 8], i == 3);
      in_data = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      int t;
      t = 0;
      while ((exp_q.size() != 0 || m_valid) && t < 500) begin
         @(negedge clk);
         t++;
      end
      check({tag, "_drain"}, exp_q.size(), 0);
      check({tag, "_good_cnt"}, {16'h0, good_cnt}, exp_good);
      check({tag, "_err_cnt"}, {16'h0, err_cnt}, exp_err);
   endtask

   initial begin
      #1;
      check("rst_m_valid", {31'h0, m_valid}, 0);
      check("rst_m_data", {24'h0, m_data}, 0);
      check("rst_m_last_user", {30'h0, m_last, m_user}, 0);
      check("rst_cnts", {good_cnt, err_cnt}, 0);
      check("rst_s_ready", {31'h0, s_ready}, 1);
      #20;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_frame(60, 1'b0);
      wait_drain("good");

      run_frame(60, 1'b1);
      wait_drain("corrupt");

      toggle_en = 1'b1;
      run_frame(60, 1'b0);
      wait_drain("backpressure");
      toggle_en = 1'b0;
      m_ready   = 1'b1;

      // No SFD, then a good frame straight after the TLAST.
      send_byte(8'h55, 1'b0);
      send_byte(8'h55, 1'b0);
      send_byte(8'hAA, 1'b0);
      for (int i = 0; i < 10; i++) send_byte(8'(8'h30 + i), i == 9);
      exp_err++;
      run_frame(60, 1'b0);
      wait_drain("nosfd_then_good");

      run_frame(20, 1'b0);
      wait_drain("runt20");

      send_byte(8'h55, 1'b0);
      send_byte(8'hD5, 1'b0);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'h33, 1'b1);
      exp_err++;
      wait_drain("runt3");

      mon_en = 1'b0;
      for (int i = 0; i < 7; i++) send_byte(8'h55, 1'b0);
      send_byte(8'hD5, 1'b0);
      for (int i = 0; i < 30; i++) send_byte(8'(i), 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_m_valid", {31'h0, m_valid}, 0);
      check("midrst_m_data", {24'h0, m_data}, 0);
      check("midrst_m_last_user", {30'h0, m_last, m_user}, 0);
      check("midrst_cnts", {good_cnt, err_cnt}, 0);
      check("midrst_s_ready", {31'h0, s_ready}, 1);
      exp_good = 0;
      exp_err  = 0;
      @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      @(posedge clk);
      #1;
      run_frame(60, 1'b0);
      wait_drain("after_reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
